// File: rtl/cnn_mac_pipe.sv
// Pipelined signed multiply-accumulate for CNN dot products: NUM_STAGE product
// registers, an accumulate stage, and a shift/saturate output register.
module cnn_mac_pipe #(
  parameter int DIN0_WIDTH = 15,
  parameter int DIN1_WIDTH = 10,
  parameter int NUM_STAGE  = 2,
  parameter int ACC_WIDTH  = 32,
  parameter int DOUT_WIDTH = 15,
  parameter int FRAC_SHIFT = 9
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DIN0_WIDTH-1:0] din0,
  input  logic signed [DIN1_WIDTH-1:0] din1,
  input  logic                         in_last,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic signed [DOUT_WIDTH-1:0] dout,
  output logic                         dout_ovf,
  output logic                         busy
);

  localparam int PW = DIN0_WIDTH + DIN1_WIDTH;
  localparam int LS = NUM_STAGE - 1;
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b0}}, {(DOUT_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN =
    {{(ACC_WIDTH-DOUT_WIDTH+1){1'b1}}, {(DOUT_WIDTH-1){1'b0}}};

  // Handshake: a beat moves on a rising edge where valid and ready are both 1.
  // The whole pipe advances only when the output register is free or being
  // popped, so in_ready is that global enable.
  logic                         w_en;
  logic signed [PW-1:0]         w_prod;
  logic signed [ACC_WIDTH-1:0]  w_p_ext;
  logic signed [ACC_WIDTH-1:0]  w_sum;
  logic signed [ACC_WIDTH-1:0]  w_shift;
  logic                         w_hi;
  logic                         w_lo;
  logic                         w_acc_v;
  logic                         w_acc_last;

  logic signed [PW-1:0]         r_p [NUM_STAGE];
  logic [NUM_STAGE-1:0]         r_v;
  logic [NUM_STAGE-1:0]         r_l;
  logic signed [ACC_WIDTH-1:0]  r_acc;
  logic                         r_part;
  logic                         r_out_valid;
  logic signed [DOUT_WIDTH-1:0] r_dout;
  logic                         r_ovf;

  assign w_en       = ~(r_out_valid & ~out_ready);
  assign w_prod     = din0 * din1;
  assign w_acc_v    = r_v[LS];
  assign w_acc_last = r_l[LS];
  assign w_p_ext    = {{(ACC_WIDTH-PW){r_p[LS][PW-1]}}, r_p[LS]};
  assign w_sum      = r_acc + w_p_ext;
  assign w_shift    = w_sum >>> FRAC_SHIFT;
  assign w_hi       = w_shift > SAT_MAX;
  assign w_lo       = w_shift < SAT_MIN;

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_v <= '0;
      r_l <= '0;
      for (int s = 0; s < NUM_STAGE; s++) r_p[s] <= '0;
    end else if (w_en) begin
      r_p[0] <= w_prod;
      r_v[0] <= in_valid;
      r_l[0] <= in_last;
      for (int s = 1; s < NUM_STAGE; s++) begin
        r_p[s] <= r_p[s-1];
        r_v[s] <= r_v[s-1];
        r_l[s] <= r_l[s-1];
      end
    end
  end

  // A last beat closes the sum: result is registered and the accumulator
  // restarts from zero so back-to-back dot products need no idle cycle.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_acc  <= '0;
      r_part <= 1'b0;
      r_dout <= '0;
      r_ovf  <= 1'b0;
    end else if (w_en && w_acc_v) begin
      if (w_acc_last) begin
        r_acc  <= '0;
        r_part <= 1'b0;
        r_ovf  <= w_hi | w_lo;
        if (w_hi)      r_dout <= SAT_MAX[DOUT_WIDTH-1:0];
        else if (w_lo) r_dout <= SAT_MIN[DOUT_WIDTH-1:0];
        else           r_dout <= w_shift[DOUT_WIDTH-1:0];
      end else begin
        r_acc  <= w_sum;
        r_part <= 1'b1;
      end
    end
  end

  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      r_out_valid <= 1'b0;
    end else if (w_en) begin
      if (w_acc_v && w_acc_last) r_out_valid <= 1'b1;
      else if (out_ready)        r_out_valid <= 1'b0;
    end
  end

  assign in_ready  = w_en;
  assign out_valid = r_out_valid;
  assign dout      = r_dout;
  assign dout_ovf  = r_ovf;
  assign busy      = r_part | (|r_v);

endmodule
